i2s_tx_frame_sched: RTL and testbench

Sequencing core of the I2S transmitter. It accepts 32-bit audio samples on an AXI-Stream slave, using TID to mark left or right. Samples are held in a two-slot stereo buffer, and the block generates SCLK, LRCLK and SDATA from aud_mclk using the programmed SCLK divider. It sits between the AXI-Stream ingress and the I2S pins, and takes its configuration from the register block.

---
 rtl/i2s_tx_10xe_defines.sv | 21 ++
 rtl/i2s_sclk_gen.sv | 47 ++++
 rtl/i2s_tx_frame_sched.sv | 200 ++++++++++++++++++++
 tb/tb_i2s_tx_frame_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_10xe_defines.sv
// Shared AXI-Stream widths, scheduler state encoding and I2S frame constants
// for the I2S transmitter.
package i2s_tx_10xe_defines;

    localparam int AXI_STREAM_DATA_WIDTH = 32;
    localparam int AXI_STREAM_TID_WIDTH  = 3;

    typedef logic [AXI_STREAM_DATA_WIDTH-1:0] axi_stream_data;
    typedef logic [AXI_STREAM_TID_WIDTH-1:0]  axi_stream_tid;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_e;

    localparam int I2S_SLOTS_PER_FRAME = 64;
    localparam int TID_LEFT            = 0;
    localparam int TID_RIGHT           = 1;

endpackage

// File: rtl/i2s_sclk_gen.sv
// SCLK divider: toggles sclk every div_i enabled cycles and strobes the
// cycle in which sclk falls. Disabling clears the counter and sclk.
module i2s_sclk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sclk_o,
    output logic                 fall_o
);

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 toggle;

    // div_i is never zero here; the scheduler clamps it before latching.
    always_comb begin
        toggle = en_i && (cnt_q == (div_i - CNT_ONE));
        cnt_d  = cnt_q + CNT_ONE;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (toggle) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign fall_o = toggle && sclk_q;

endmodule

// File: rtl/i2s_tx_frame_sched.sv
// I2S transmit sequencer: buffers one stereo pair from AXI-Stream and
// serialises it MSB first as 64-slot frames on SCLK/LRCLK/SDATA.
module i2s_tx_frame_sched
    import i2s_tx_10xe_defines::*;
#(
    parameter int DATA_WIDTH = AXI_STREAM_DATA_WIDTH,
    parameter int TID_WIDTH  = AXI_STREAM_TID_WIDTH,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  aud_mclk,
    input  logic                  aud_mrst,
    input  logic                  cfg_en,
    input  logic [DIV_WIDTH-1:0]  cfg_sclk_div,
    input  logic [DATA_WIDTH-1:0] s_axis_aud_tdata,
    input  logic [TID_WIDTH-1:0]  s_axis_aud_tid,
    input  logic                  s_axis_aud_tvalid,
    output logic                  s_axis_aud_tready,
    output logic                  sclk_out,
    output logic                  lrclk_out,
    output logic                  sdata_out,
    output logic                  underflow,
    output logic                  tid_err,
    output logic                  frame_start,
    output sched_state_e          dbg_state
);

    localparam int SLOTS  = I2S_SLOTS_PER_FRAME * DATA_WIDTH / AXI_STREAM_DATA_WIDTH;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam logic [SLOT_W-1:0]    SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0]    LR_FIRST  = SLOT_W'(DATA_WIDTH - 1);
    localparam logic [SLOT_W-1:0]    LR_LAST   = SLOT_W'(SLOTS - 2);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    sched_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d;
    logic [DATA_WIDTH-1:0]   l_buf_q, l_buf_d, r_buf_q, r_buf_d;
    logic                    l_vld_q, l_vld_d, r_vld_q, r_vld_d;
    logic [SLOTS-1:0]        sh_q, sh_d;
    logic [SLOT_W-1:0]       slot_q, slot_d, slot_nx;
    logic                    lr_q, lr_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underflow_q, underflow_d;
    logic                    tid_err_q, tid_err_d;

    logic is_left, is_right, chan_free, ingress_on, accept;
    logic sclk_en, sclk_fall;

    // Handshake: a beat transfers on a rising aud_mclk edge where tvalid and
    // tready are both high; tready never depends on tvalid. A channel whose
    // slot is already full holds tready low, invalid TIDs are always taken.
    assign is_left    = (s_axis_aud_tid == TID_WIDTH'(TID_LEFT));
    assign is_right   = (s_axis_aud_tid == TID_WIDTH'(TID_RIGHT));
    assign ingress_on = (state_q != IDLE) && cfg_en;

    always_comb begin
        if (is_left) begin
            chan_free = !l_vld_q;
        end else if (is_right) begin
            chan_free = !r_vld_q;
        end else begin
            chan_free = 1'b1;
        end
    end

    assign s_axis_aud_tready = ingress_on && chan_free;
    assign accept            = s_axis_aud_tready && s_axis_aud_tvalid;

    assign sclk_en = (state_q == RUN) && cfg_en;

    i2s_sclk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sclk_gen (
        .clk_i  (aud_mclk),
        .rst_i  (aud_mrst),
        .en_i   (sclk_en),
        .div_i  (div_q),
        .sclk_o (sclk_out),
        .fall_o (sclk_fall)
    );

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        l_buf_d       = l_buf_q;
        r_buf_d       = r_buf_q;
        l_vld_d       = l_vld_q;
        r_vld_d       = r_vld_q;
        sh_d          = sh_q;
        slot_d        = slot_q;
        lr_d          = lr_q;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;
        tid_err_d     = 1'b0;
        slot_nx       = slot_q + SLOT_ONE;

        if (accept) begin
            if (is_left) begin
                l_buf_d = s_axis_aud_tdata;
                l_vld_d = 1'b1;
            end else if (is_right) begin
                r_buf_d = s_axis_aud_tdata;
                r_vld_d = 1'b1;
            end else begin
                tid_err_d = 1'b1;
            end
        end

        if (!cfg_en) begin
            state_d = IDLE;
            l_vld_d = 1'b0;
            r_vld_d = 1'b0;
            sh_d    = '0;
            slot_d  = '0;
            lr_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRIME;
                    div_d   = (cfg_sclk_div == '0) ? DIV_ONE : cfg_sclk_div;
                end
                PRIME: begin
                    if (l_vld_q && r_vld_q) begin
                        state_d       = RUN;
                        sh_d          = {l_buf_q, r_buf_q};
                        l_vld_d       = 1'b0;
                        r_vld_d       = 1'b0;
                        slot_d        = '0;
                        lr_d          = 1'b0;
                        frame_start_d = 1'b1;
                    end
                end
                RUN: begin
                    if (sclk_fall) begin
                        if (slot_q == SLOT_LAST) begin
                            // Frame boundary: a missing channel sends a silent
                            // frame but keeps whatever half-pair has arrived.
                            slot_d        = '0;
                            lr_d          = 1'b0;
                            frame_start_d = 1'b1;
                            if (l_vld_q && r_vld_q) begin
                                sh_d    = {l_buf_q, r_buf_q};
                                l_vld_d = 1'b0;
                                r_vld_d = 1'b0;
                            end else begin
                                sh_d        = '0;
                                underflow_d = 1'b1;
                            end
                        end else begin
                            slot_d = slot_nx;
                            sh_d   = {sh_q[SLOTS-2:0], 1'b0};
                            lr_d   = (slot_nx >= LR_FIRST) && (slot_nx <= LR_LAST);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            l_buf_q       <= '0;
            r_buf_q       <= '0;
            l_vld_q       <= 1'b0;
            r_vld_q       <= 1'b0;
            sh_q          <= '0;
            slot_q        <= '0;
            lr_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            tid_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            l_buf_q       <= l_buf_d;
            r_buf_q       <= r_buf_d;
            l_vld_q       <= l_vld_d;
            r_vld_q       <= r_vld_d;
            sh_q          <= sh_d;
            slot_q        <= slot_d;
            lr_q          <= lr_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            tid_err_q     <= tid_err_d;
        end
    end

    assign sdata_out   = sh_q[SLOTS-1];
    assign lrclk_out   = lr_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign tid_err     = tid_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2s_tx_frame_sched.sv
// Directed bench for i2s_tx_frame_sched: stimulus pushes expected frames,
// a frame monitor deserialises SDATA/LRCLK and checks them in order.
module tb_i2s_tx_frame_sched;
    import i2s_tx_10xe_defines::*;

    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_en = 1'b0;
    logic [7:0]  cfg_sclk_div = 8'd1;
    logic [31:0] s_tdata = '0;
    logic [2:0]  s_tid = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        sclk, lrclk, sdata, underflow, tid_err, frame_start;
    sched_state_e dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_div = 1;
    int fs_cnt = 0;
    int uf_cnt = 0;
    int te_cnt = 0;
    int nbits = 0;
    logic [64:0] exp_q[$];

    i2s_tx_frame_sched dut (
        .aud_mclk          (clk),
        .aud_mrst          (rst),
        .cfg_en            (cfg_en),
        .cfg_sclk_div      (cfg_sclk_div),
        .s_axis_aud_tdata  (s_tdata),
        .s_axis_aud_tid    (s_tid),
        .s_axis_aud_tvalid (s_tvalid),
        .s_axis_aud_tready (s_tready),
        .sclk_out          (sclk),
        .lrclk_out         (lrclk),
        .sdata_out         (sdata),
        .underflow         (underflow),
        .tid_err           (tid_err),
        .frame_start       (frame_start),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    initial begin
        forever #5 clk = ~clk;
    end

    // frame monitor: pops one expected frame per 64 captured bits
    initial begin
        logic [63:0] bits_w;
        logic [63:0] lr_w;
        logic [64:0] exp_f;
        logic        collecting;
        logic        cur_uf;
        logic        have_prev;
        logic        prev_sclk;
        int          cyc;
        bits_w = '0; lr_w = '0; exp_f = '0;
        collecting = 1'b0; cur_uf = 1'b0; have_prev = 1'b0; prev_sclk = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            if (underflow) uf_cnt++;
            if (tid_err) te_cnt++;
            if (rst || !cfg_en) begin
                collecting = 1'b0;
                nbits = 0;
                have_prev = 1'b0;
                prev_sclk = 1'b0;
            end else begin
                cyc++;
                if (frame_start) begin
                    fs_cnt++;
                    if (have_prev) begin
                        n_cmp++;
                        if (cyc != 128 * exp_div) begin
                            n_fail++;
                            $display("FAIL frame_period: got %0d cycles, expected %0d", cyc, 128 * exp_div);
                        end
                    end
                    have_prev = 1'b1;
                    cyc = 0;
                    collecting = 1'b1;
                    nbits = 0;
                    cur_uf = underflow;
                end
                if (collecting && sclk && !prev_sclk) begin
                    bits_w = {bits_w[62:0], sdata};
                    lr_w   = {lr_w[62:0], lrclk};
                    nbits++;
                    if (nbits == 64) begin
                        collecting = 1'b0;
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL frame_unexpected: got uf=%0b data=%h, expected no frame", cur_uf, bits_w);
                        end else begin
                            exp_f = exp_q.pop_front();
                            if ({cur_uf, bits_w} !== exp_f) begin
                                n_fail++;
                                $display("FAIL frame_data: got uf=%0b data=%h, expected uf=%0b data=%h",
                                         cur_uf, bits_w, exp_f[64], exp_f[63:0]);
                            end
                        end
                        n_cmp++;
                        if (lr_w !== LR_EXP) begin
                            n_fail++;
                            $display("FAIL frame_lrclk: got %h, expected %h", lr_w, LR_EXP);
                        end
                    end
                end
                prev_sclk = sclk;
            end
        end
    end

    // driver tasks
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tid    = t;
        s_tdata  = d;
        #1;
        while (!s_tready && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (!s_tready) begin
            n_fail++;
            $display("FAIL send_accept: got no tready after %0d cycles, expected accept (tid=%0d)", n, t);
        end else begin
            @(posedge clk);
        end
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic enable(input logic [7:0] div_cfg, input int ediv);
        @(negedge clk);
        cfg_sclk_div = div_cfg;
        exp_div      = ediv;
        cfg_en       = 1'b1;
    endtask

    task automatic disable_core();
        @(negedge clk);
        cfg_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_frame(input logic uf, input logic [31:0] l, input logic [31:0] r);
        exp_q.push_back({uf, l, r});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d frames outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_fs(input int target, input int budget);
        int n;
        n = 0;
        while (fs_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_seen", 64'(fs_cnt >= target), 64'd1);
    endtask

    // stimulus
    initial begin
        int fs0;
        int uf0;
        int te0;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_lrclk", 64'(lrclk), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_tid_err", 64'(tid_err), 64'd0);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tready", 64'(s_tready), 64'd0);

        // div=1 basic frame, frame_start latency after the R accept
        push_frame(1'b0, 32'hA5A5_0001, 32'h5A5A_8000);
        enable(8'd1, 1);
        @(negedge clk);
        chk("prime_state", 64'(dbg_state), 64'(PRIME));
        send(3'd0, 32'hA5A5_0001);
        send(3'd1, 32'h5A5A_8000);
        @(negedge clk);
        chk("fs_not_yet", 64'(frame_start), 64'd0);
        @(negedge clk);
        chk("fs_latency", 64'(frame_start), 64'd1);
        chk("fs_first_bit", 64'(sdata), 64'd1);
        chk("run_state", 64'(dbg_state), 64'(RUN));
        drain(400);
        wait_fs(fs_cnt + 1, 400);
        disable_core();

        // cfg_sclk_div=0 behaves as div=1
        push_frame(1'b0, 32'h8000_0001, 32'hFFFF_0000);
        push_frame(1'b1, 32'h0000_0000, 32'h0000_0000);
        enable(8'd0, 1);
        send(3'd0, 32'h8000_0001);
        send(3'd1, 32'hFFFF_0000);
        drain(600);
        disable_core();

        // div=4: three pairs then starvation, duplicate channel stalls
        push_frame(1'b0, 32'hC0FF_EE00, 32'h0000_00FF);
        push_frame(1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
        push_frame(1'b0, 32'h0123_4567, 32'h89AB_CDEF);
        push_frame(1'b1, 32'h0000_0000, 32'h0000_0000);
        enable(8'd4, 4);
        send(3'd0, 32'hC0FF_EE00);
        send(3'd1, 32'h0000_00FF);
        send(3'd0, 32'h7FFF_FFFF);
        send(3'd1, 32'h8000_0000);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tid    = 3'd0;
        #1;
        chk("dup_left_stall", 64'(s_tready), 64'd0);
        s_tid = 3'd1;
        #1;
        chk("dup_right_stall", 64'(s_tready), 64'd0);
        s_tid = 3'd6;
        #1;
        chk("bad_tid_ready", 64'(s_tready), 64'd1);
        s_tvalid = 1'b0;
        te0 = te_cnt;
        send(3'd0, 32'h0123_4567);
        send(3'd1, 32'h89AB_CDEF);
        drain(6000);
        chk("bad_tid_not_taken", 64'(te_cnt - te0), 64'd0);
        disable_core();

        // left only in RUN, invalid TID, left retained across the silent frame
        push_frame(1'b0, 32'h1357_9BDF, 32'h2468_ACE0);
        push_frame(1'b1, 32'h0000_0000, 32'h0000_0000);
        fs0 = fs_cnt;
        uf0 = uf_cnt;
        te0 = te_cnt;
        enable(8'd1, 1);
        send(3'd0, 32'h1357_9BDF);
        send(3'd1, 32'h2468_ACE0);
        send(3'd5, 32'hFFFF_FFFF);
        send(3'd0, 32'hDEAD_BEEF);
        wait_fs(fs0 + 2, 400);
        chk("underflow_pulses", 64'(uf_cnt - uf0), 64'd1);
        chk("tid_err_pulses", 64'(te_cnt - te0), 64'd1);
        send(3'd1, 32'h0F0F_F0F0);
        push_frame(1'b0, 32'hDEAD_BEEF, 32'h0F0F_F0F0);
        drain(600);
        disable_core();

        // divider latched at enable; live changes ignored until re-enable
        push_frame(1'b0, 32'hAAAA_5555, 32'h3333_CCCC);
        push_frame(1'b1, 32'h0000_0000, 32'h0000_0000);
        enable(8'd2, 2);
        send(3'd0, 32'hAAAA_5555);
        send(3'd1, 32'h3333_CCCC);
        @(negedge clk);
        cfg_sclk_div = 8'd8;
        drain(1200);
        disable_core();
        push_frame(1'b0, 32'hF00D_CAFE, 32'h0BAD_F00D);
        push_frame(1'b1, 32'h0000_0000, 32'h0000_0000);
        enable(8'd8, 8);
        send(3'd0, 32'hF00D_CAFE);
        send(3'd1, 32'h0BAD_F00D);
        drain(4000);
        disable_core();

        // abort at slot 40: mode 0 drops cfg_en, mode 1 asserts reset
        for (int mode = 0; mode < 2; mode++) begin
            enable(8'd4, 4);
            send(3'd0, 32'h1234_5678);
            send(3'd1, 32'h00FF_0000);
            send(3'd0, 32'hFFFF_FFFF);
            n = 0;
            while (nbits < 41 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reach_slot40", 64'(nbits >= 41), 64'd1);
            chk("abort_lrclk_high", 64'(lrclk), 64'd1);
            @(negedge clk);
            if (mode == 0) cfg_en = 1'b0;
            else rst = 1'b1;
            @(negedge clk);
            chk("abort_sclk", 64'(sclk), 64'd0);
            chk("abort_lrclk", 64'(lrclk), 64'd0);
            chk("abort_sdata", 64'(sdata), 64'd0);
            chk("abort_tready", 64'(s_tready), 64'd0);
            chk("abort_pulses", 64'({frame_start, underflow, tid_err}), 64'd0);
            chk("abort_state", 64'(dbg_state), 64'(IDLE));
            if (mode == 0) cfg_en = 1'b1;
            else rst = 1'b0;
            @(negedge clk);
            chk("reenable_state", 64'(dbg_state), 64'(PRIME));
            fs0 = fs_cnt;
            send(3'd1, 32'h0000_0003);
            repeat (20) @(negedge clk);
            chk("buffers_flushed", 64'(fs_cnt - fs0), 64'd0);
            push_frame(1'b0, 32'h4000_0000, 32'h0000_0003);
            send(3'd0, 32'h4000_0000);
            drain(1500);
            disable_core();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // bounded run
    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected bench to complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
